// File: rtl/video_mem_pkg.sv
// Shared types and widths for the video memory arbiter slice.
package video_mem_pkg;

  localparam int unsigned VM_ADDR_W = 16;
  localparam int unsigned VM_DATA_W = 3;

  // ST_CLEAR is only reachable when VIDEO_CLEAR_ENGINE_EN is defined.
  typedef enum logic [0:0] {
    ST_IDLE,
    ST_CLEAR
  } vm_state_e;

  // One pixel: {R,G,B}.
  typedef logic [VM_DATA_W-1:0] pixel_t;

endpackage

// File: rtl/video_memory_arbiter_if.sv
// Bus bundle around the video memory arbiter: VGA read port, CPU write port, RAM port.
// VIDEO_CLEAR_ENGINE_EN adds the clear-engine signals.
interface video_mem_if
  import video_mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = VM_ADDR_W,
  parameter int unsigned DATA_W      = VM_DATA_W,
  parameter int unsigned WFIFO_DEPTH = 4
);

  localparam int unsigned LEVEL_W = $clog2(WFIFO_DEPTH) + 1;

  logic              iVgaReadEn;
  logic [ADDR_W-1:0] iVgaReadAddress;
  logic [DATA_W-1:0] oVgaReadData;
  logic              oVgaReadValid;

  logic               iCpuWriteValid;
  logic               oCpuWriteReady;
  logic [ADDR_W-1:0]  iCpuWriteAddress;
  logic [DATA_W-1:0]  iCpuWriteData;
  logic [LEVEL_W-1:0] oWriteFifoLevel;

  logic [ADDR_W-1:0] oRamAddress;
  logic              oRamWriteEnable;
  logic [DATA_W-1:0] oRamWriteData;
  logic [DATA_W-1:0] iRamReadData;

`ifdef VIDEO_CLEAR_ENGINE_EN
  logic              iClearStart;
  logic [DATA_W-1:0] iClearColor;
  logic              oClearBusy;
`endif

  // Arbiter side.
  modport slave (
    input  iVgaReadEn, iVgaReadAddress, iCpuWriteValid, iCpuWriteAddress, iCpuWriteData,
    input  iRamReadData,
`ifdef VIDEO_CLEAR_ENGINE_EN
    input  iClearStart, iClearColor,
    output oClearBusy,
`endif
    output oVgaReadData, oVgaReadValid, oCpuWriteReady, oWriteFifoLevel,
    output oRamAddress, oRamWriteEnable, oRamWriteData
  );

  // Requester / RAM side.
  modport master (
    output iVgaReadEn, iVgaReadAddress, iCpuWriteValid, iCpuWriteAddress, iCpuWriteData,
    output iRamReadData,
`ifdef VIDEO_CLEAR_ENGINE_EN
    output iClearStart, iClearColor,
    input  oClearBusy,
`endif
    input  oVgaReadData, oVgaReadValid, oCpuWriteReady, oWriteFifoLevel,
    input  oRamAddress, oRamWriteEnable, oRamWriteData
  );

endinterface

// File: rtl/video_write_fifo.sv
// Synchronous circular FIFO used to post CPU writes. Depth must be a power of 2.
module video_write_fifo #(
  parameter int unsigned Width = 19,
  parameter int unsigned Depth = 4
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   push,
  input  logic [Width-1:0]       push_data,
  input  logic                   pop,
  output logic [Width-1:0]       pop_data,
  output logic [$clog2(Depth):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PtrW   = $clog2(Depth);
  localparam int unsigned CountW = PtrW + 1;

  logic [Width-1:0]  mem_q [Depth];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CountW-1:0] count_q, count_d;
  logic              do_push, do_pop;

  assign full     = (count_q == CountW'(Depth));
  assign empty    = (count_q == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

  // Occupancy update; simultaneous push and pop cancel out.
  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CountW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CountW'(1);
    end
  end

  // Pointer and count registers; pointers wrap naturally at Depth.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge Clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/video_memory_arbiter.sv
// Single-port video RAM arbiter: VGA reads always win, posted CPU writes drain into idle
// cycles. Optional full-screen clear engine under VIDEO_CLEAR_ENGINE_EN.
module video_memory_arbiter
  import video_mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = VM_ADDR_W,
  parameter int unsigned DATA_W      = VM_DATA_W,
  parameter int unsigned WFIFO_DEPTH = 4
) (
  input logic         Clock,
  input logic         Reset,
  video_mem_if.slave  bus
);

  localparam int unsigned EntryW = ADDR_W + DATA_W;
  localparam int unsigned LevelW = $clog2(WFIFO_DEPTH) + 1;

  vm_state_e         state_q, state_d;
  logic              vga_valid_q;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [EntryW-1:0] push_entry, head_entry;
  logic [LevelW-1:0] fifo_count;

`ifdef VIDEO_CLEAR_ENGINE_EN
  logic [ADDR_W-1:0] clear_cnt_q, clear_cnt_d;
  logic [DATA_W-1:0] clear_color_q, clear_color_d;
  assign bus.oClearBusy = (state_q == ST_CLEAR);
`endif

  // Ready comes from the registered count only: no bypass when a pop frees a slot.
  assign push_entry          = {bus.iCpuWriteAddress, bus.iCpuWriteData};
  assign fifo_push           = bus.iCpuWriteValid && !fifo_full;
  assign bus.oCpuWriteReady  = !fifo_full;
  assign bus.oWriteFifoLevel = fifo_count;
  assign bus.oVgaReadValid   = vga_valid_q;
  assign bus.oVgaReadData    = bus.iRamReadData;

  video_write_fifo #(
    .Width (EntryW),
    .Depth (WFIFO_DEPTH)
  ) u_wfifo (
    .Clock     (Clock),
    .Reset     (Reset),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .pop_data  (head_entry),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // RAM slot selection: VGA read, then clear engine, then FIFO head, else idle.
  always_comb begin
    bus.oRamAddress     = '0;
    bus.oRamWriteEnable = 1'b0;
    bus.oRamWriteData   = '0;
    fifo_pop            = 1'b0;
    if (bus.iVgaReadEn) begin
      bus.oRamAddress = bus.iVgaReadAddress;
    end
`ifdef VIDEO_CLEAR_ENGINE_EN
    else if (state_q == ST_CLEAR) begin
      bus.oRamAddress     = clear_cnt_q;
      bus.oRamWriteEnable = 1'b1;
      bus.oRamWriteData   = clear_color_q;
    end
`endif
    // Queued writes are being discarded by reset, so never let one escape that cycle.
    else if (!Reset && state_q == ST_IDLE && !fifo_empty) begin
      bus.oRamAddress     = head_entry[EntryW-1:DATA_W];
      bus.oRamWriteEnable = 1'b1;
      bus.oRamWriteData   = head_entry[DATA_W-1:0];
      fifo_pop            = 1'b1;
    end
  end

  // Next-state logic for the clear engine; without it the state stays ST_IDLE.
  always_comb begin
    state_d = state_q;
`ifdef VIDEO_CLEAR_ENGINE_EN
    clear_cnt_d   = clear_cnt_q;
    clear_color_d = clear_color_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.iClearStart) begin
          clear_color_d = bus.iClearColor;
          clear_cnt_d   = '0;
          state_d       = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        // Only advance in cycles the VGA reader left free.
        if (!bus.iVgaReadEn) begin
          clear_cnt_d = clear_cnt_q + ADDR_W'(1);
          if (clear_cnt_q == '1) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
`else
    state_d = ST_IDLE;
`endif
  end

  // State, clear registers and the one-cycle VGA valid pipeline.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      vga_valid_q <= 1'b0;
`ifdef VIDEO_CLEAR_ENGINE_EN
      clear_cnt_q   <= '0;
      clear_color_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      vga_valid_q <= bus.iVgaReadEn;
`ifdef VIDEO_CLEAR_ENGINE_EN
      clear_cnt_q   <= clear_cnt_d;
      clear_color_q <= clear_color_d;
`endif
    end
  end

endmodule

// File: tb/tb_video_memory_arbiter.sv
// Directed self-checking bench for video_memory_arbiter with a behavioural 1-cycle RAM.
module tb_video_memory_arbiter;
  import video_mem_pkg::*;

  localparam int unsigned AW    = 16;
  localparam int unsigned DW    = 3;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  video_mem_if #(.ADDR_W(AW), .DATA_W(DW), .WFIFO_DEPTH(DEPTH)) bus ();

  video_memory_arbiter #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .WFIFO_DEPTH (DEPTH)
  ) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Video RAM model: synchronous write, registered read.
  logic [DW-1:0] ram [2**AW];
  always @(posedge clk) begin
    if (bus.oRamWriteEnable) ram[bus.oRamAddress] <= bus.oRamWriteData;
    bus.iRamReadData <= ram[bus.oRamAddress];
  end

  // Cycle step: land 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.iVgaReadEn = 1'b0; bus.iVgaReadAddress = '0;
    bus.iCpuWriteValid = 1'b0; bus.iCpuWriteAddress = '0; bus.iCpuWriteData = '0;
`ifdef VIDEO_CLEAR_ENGINE_EN
    bus.iClearStart = 1'b0; bus.iClearColor = '0;
`endif
    rst = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;
    #1;
    total++; if (bus.oVgaReadValid !== 1'b0) begin bad++;
      $display("FAIL reset_valid got=%b want=0", bus.oVgaReadValid); end
    total++; if (bus.oWriteFifoLevel !== 3'd0) begin bad++;
      $display("FAIL reset_level got=%0d want=0", bus.oWriteFifoLevel); end
    total++; if (bus.oCpuWriteReady !== 1'b1) begin bad++;
      $display("FAIL reset_ready got=%b want=1", bus.oCpuWriteReady); end
    total++; if ({bus.oRamWriteEnable, bus.oRamAddress} !== {1'b0, 16'h0000}) begin bad++;
      $display("FAIL reset_ram got we=%b a=%h want we=0 a=0000", bus.oRamWriteEnable,
               bus.oRamAddress); end
`ifdef VIDEO_CLEAR_ENGINE_EN
    total++; if (bus.oClearBusy !== 1'b0) begin bad++;
      $display("FAIL reset_busy got=%b want=0", bus.oClearBusy); end
`endif
  endtask

  task automatic test_vga_read();
    ram[16'h1234] = 3'b110;
    cyc();
    bus.iVgaReadEn = 1'b1; bus.iVgaReadAddress = 16'h1234;
    #1;
    total++; if ({bus.oRamWriteEnable, bus.oRamAddress} !== {1'b0, 16'h1234}) begin bad++;
      $display("FAIL vga_slot got we=%b a=%h want we=0 a=1234", bus.oRamWriteEnable,
               bus.oRamAddress); end
    cyc();
    bus.iVgaReadEn = 1'b0;
    #1;
    total++; if ({bus.oVgaReadValid, bus.oVgaReadData} !== {1'b1, 3'b110}) begin bad++;
      $display("FAIL vga_data got v=%b d=%b want v=1 d=110", bus.oVgaReadValid,
               bus.oVgaReadData); end
    cyc();
    total++; if (bus.oVgaReadValid !== 1'b0) begin bad++;
      $display("FAIL vga_valid_drop got=%b want=0", bus.oVgaReadValid); end
  endtask

  task automatic test_cpu_write();
    cyc();
    bus.iCpuWriteValid = 1'b1; bus.iCpuWriteAddress = 16'h0010; bus.iCpuWriteData = 3'b101;
    #1;
    total++; if ({bus.oCpuWriteReady, bus.oRamWriteEnable} !== 2'b10) begin bad++;
      $display("FAIL wr_accept got rdy=%b we=%b want rdy=1 we=0", bus.oCpuWriteReady,
               bus.oRamWriteEnable); end
    cyc();
    bus.iCpuWriteValid = 1'b0;
    #1;
    total++; if (bus.oWriteFifoLevel !== 3'd1) begin bad++;
      $display("FAIL wr_level1 got=%0d want=1", bus.oWriteFifoLevel); end
    total++; if ({bus.oRamWriteEnable, bus.oRamAddress, bus.oRamWriteData} !==
                 {1'b1, 16'h0010, 3'b101}) begin bad++;
      $display("FAIL wr_ram got we=%b a=%h d=%b want we=1 a=0010 d=101", bus.oRamWriteEnable,
               bus.oRamAddress, bus.oRamWriteData); end
    cyc();
    total++; if ({bus.oWriteFifoLevel, bus.oRamWriteEnable} !== {3'd0, 1'b0}) begin bad++;
      $display("FAIL wr_drained got lvl=%0d we=%b want lvl=0 we=0", bus.oWriteFifoLevel,
               bus.oRamWriteEnable); end
    total++; if (ram[16'h0010] !== 3'b101) begin bad++;
      $display("FAIL wr_mem got=%b want=101", ram[16'h0010]); end
  endtask

  task automatic test_starvation();
    logic [AW-1:0] ea;
    pixel_t        ed;
    cyc();
    bus.iVgaReadEn = 1'b1; bus.iVgaReadAddress = 16'h0100; bus.iCpuWriteValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.iCpuWriteAddress = 16'(16'h0200 + i); bus.iCpuWriteData = 3'(i + 1);
      #1;
      total++; if (bus.oCpuWriteReady !== (i < 4)) begin bad++;
        $display("FAIL starve_ready[%0d] got=%b want=%b", i, bus.oCpuWriteReady, (i < 4)); end
      total++; if (bus.oRamWriteEnable !== 1'b0) begin bad++;
        $display("FAIL starve_nowrite[%0d] got=%b want=0", i, bus.oRamWriteEnable); end
      cyc();
    end
    total++; if (bus.oWriteFifoLevel !== 3'd4) begin bad++;
      $display("FAIL starve_level got=%0d want=4", bus.oWriteFifoLevel); end
    bus.iVgaReadEn = 1'b0;
    for (int j = 0; j < 6; j++) begin
      #1;
      ea = 16'(16'h0200 + j); ed = 3'(j + 1);
      if (j < 5) begin
        total++; if ({bus.oRamWriteEnable, bus.oRamAddress, bus.oRamWriteData} !==
                     {1'b1, ea, ed}) begin bad++;
          $display("FAIL drain[%0d] got we=%b a=%h d=%b want we=1 a=%h d=%b", j,
                   bus.oRamWriteEnable, bus.oRamAddress, bus.oRamWriteData, ea, ed); end
      end else begin
        total++; if (bus.oRamWriteEnable !== 1'b0) begin bad++;
          $display("FAIL drain_done got we=%b want=0", bus.oRamWriteEnable); end
      end
      if (j == 0) begin
        total++; if (bus.oCpuWriteReady !== 1'b0) begin bad++;
          $display("FAIL no_bypass got rdy=%b want=0", bus.oCpuWriteReady); end
      end
      if (j == 1) begin
        total++; if (bus.oCpuWriteReady !== 1'b1) begin bad++;
          $display("FAIL ready_back got rdy=%b want=1", bus.oCpuWriteReady); end
      end
      cyc();
      if (j == 1) bus.iCpuWriteValid = 1'b0;
    end
    total++; if (bus.oWriteFifoLevel !== 3'd0) begin bad++;
      $display("FAIL starve_empty got=%0d want=0", bus.oWriteFifoLevel); end
  endtask

  task automatic test_alternate();
    logic          prev_en;
    pixel_t        prev_d;
    int            k;
    logic [AW-1:0] ea;
    cyc();
    bus.iVgaReadEn = 1'b1; bus.iVgaReadAddress = 16'h1234; bus.iCpuWriteValid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.iCpuWriteAddress = 16'(16'h0300 + i); bus.iCpuWriteData = 3'(7 - i);
      cyc();
    end
    bus.iCpuWriteValid = 1'b0;
    total++; if (bus.oWriteFifoLevel !== 3'd4) begin bad++;
      $display("FAIL alt_fill got=%0d want=4", bus.oWriteFifoLevel); end
    prev_en = 1'b1; prev_d = 3'b110; k = 0;
    for (int j = 0; j < 8; j++) begin
      bus.iVgaReadEn = (j % 2 == 0);
      bus.iVgaReadAddress = (j % 4 == 0) ? 16'h1234 : 16'h0010;
      #1;
      total++; if (bus.oVgaReadValid !== prev_en) begin bad++;
        $display("FAIL alt_valid[%0d] got=%b want=%b", j, bus.oVgaReadValid, prev_en); end
      if (prev_en) begin
        total++; if (bus.oVgaReadData !== prev_d) begin bad++;
          $display("FAIL alt_rdata[%0d] got=%b want=%b", j, bus.oVgaReadData, prev_d); end
      end
      if (bus.iVgaReadEn) begin
        total++; if ({bus.oRamWriteEnable, bus.oRamAddress} !== {1'b0, bus.iVgaReadAddress})
        begin bad++;
          $display("FAIL alt_read[%0d] got we=%b a=%h want we=0 a=%h", j, bus.oRamWriteEnable,
                   bus.oRamAddress, bus.iVgaReadAddress); end
      end else begin
        ea = 16'(16'h0300 + k);
        total++; if ({bus.oRamWriteEnable, bus.oRamAddress, bus.oRamWriteData} !==
                     {1'b1, ea, 3'(7 - k)}) begin bad++;
          $display("FAIL alt_write[%0d] got we=%b a=%h d=%b want we=1 a=%h d=%b", j,
                   bus.oRamWriteEnable, bus.oRamAddress, bus.oRamWriteData, ea, 3'(7 - k)); end
        k++;
      end
      prev_en = bus.iVgaReadEn;
      prev_d  = (bus.iVgaReadAddress == 16'h1234) ? 3'b110 : 3'b101;
      cyc();
    end
    bus.iVgaReadEn = 1'b0;
    total++; if (bus.oWriteFifoLevel !== 3'd0) begin bad++;
      $display("FAIL alt_empty got=%0d want=0", bus.oWriteFifoLevel); end
  endtask

  task automatic test_reset_flush();
    cyc();
    bus.iVgaReadEn = 1'b1; bus.iCpuWriteValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.iCpuWriteAddress = 16'(16'h0400 + i); bus.iCpuWriteData = 3'b001;
      cyc();
    end
    bus.iCpuWriteValid = 1'b0;
    total++; if (bus.oWriteFifoLevel !== 3'd3) begin bad++;
      $display("FAIL flush_fill got=%0d want=3", bus.oWriteFifoLevel); end
    rst = 1'b1;
    cyc();
    rst = 1'b0; bus.iVgaReadEn = 1'b0;
    for (int j = 0; j < 3; j++) begin
      #1;
      total++; if ({bus.oWriteFifoLevel, bus.oCpuWriteReady, bus.oRamWriteEnable} !==
                   {3'd0, 1'b1, 1'b0}) begin bad++;
        $display("FAIL flush[%0d] got lvl=%0d rdy=%b we=%b want lvl=0 rdy=1 we=0", j,
                 bus.oWriteFifoLevel, bus.oCpuWriteReady, bus.oRamWriteEnable); end
      cyc();
    end
  endtask

`ifdef VIDEO_CLEAR_ENGINE_EN
  task automatic test_clear();
    int   idx;
    int   errs;
    logic landed;
    idx = 0; errs = 0; landed = 1'b0;
    cyc();
    bus.iClearStart = 1'b1; bus.iClearColor = 3'b010;
    #1;
    cyc();
    bus.iClearStart = 1'b0;
    #1;
    total++; if (bus.oClearBusy !== 1'b1) begin bad++;
      $display("FAIL clear_busy got=%b want=1", bus.oClearBusy); end
    for (int n = 0; n < 70000; n++) begin
      if (bus.oRamWriteEnable) begin
        if (idx < 65536) begin
          if ({bus.oRamAddress, bus.oRamWriteData} !== {16'(idx), 3'b010}) errs++;
          idx++;
        end else if ({bus.oRamAddress, bus.oRamWriteData} === {16'h0005, 3'b111}) begin
          landed = 1'b1;
        end else begin
          errs++;
        end
      end
      cyc();
      bus.iCpuWriteValid = (n == 99); bus.iCpuWriteAddress = 16'h0005;
      bus.iCpuWriteData = 3'b111;
      bus.iClearStart = (n == 199); bus.iClearColor = (n == 199) ? 3'b111 : 3'b010;
      #1;
      if (landed && !bus.oClearBusy) break;
    end
    total++; if (errs !== 0) begin bad++;
      $display("FAIL clear_seq got errs=%0d want=0", errs); end
    total++; if (idx !== 65536) begin bad++;
      $display("FAIL clear_count got=%0d want=65536", idx); end
    total++; if (landed !== 1'b1) begin bad++;
      $display("FAIL clear_posted got=%b want=1", landed); end
    total++; if (bus.oClearBusy !== 1'b0) begin bad++;
      $display("FAIL clear_done got=%b want=0", bus.oClearBusy); end
    total++; if (ram[16'h0005] !== 3'b111) begin bad++;
      $display("FAIL clear_last_wins got=%b want=111", ram[16'h0005]); end
  endtask
`endif

  initial begin
    test_reset();
    test_vga_read();
    test_cpu_write();
    test_starvation();
    test_alternate();
    test_reset_flush();
`ifdef VIDEO_CLEAR_ENGINE_EN
    test_clear();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
